// File: rtl/vga_line_fetch_pkg.sv
// ============================================================================
// Module : vga_line_fetch_pkg
// Brief  : 640x480 timing constants and fetch FSM state type for the line fetcher.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_line_fetch_pkg;

    localparam int c_h_visible = 640;
    localparam int c_v_visible = 480;
    localparam int c_h_total   = 800;
    localparam int c_v_total   = 525;
    localparam int c_pix_w     = 12;
    localparam int c_mem_aw    = 19;
    localparam int c_fb_base   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_line_fetch_if.sv
// ============================================================================
// Module : vga_line_fetch_if
// Brief  : Framebuffer read port: valid/ready request, in-order response.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_line_fetch_if
    import vga_line_fetch_pkg::*;
#(
    parameter int MEM_AW = c_mem_aw,
    parameter int PIX_W  = c_pix_w
);

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [MEM_AW-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [PIX_W-1:0]  mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );

endinterface

`default_nettype wire

// File: rtl/vga_line_fetch_ram.sv
// ============================================================================
// Module : vga_line_ram
// Brief  : Ping-pong line buffer, one write port and one registered read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_line_ram #(
    parameter int DATA_W   = 12,
    parameter int LINE_LEN = 640
) (
    input  wire logic                        clk_pix,
    input  wire logic                        we,
    input  wire logic [$clog2(LINE_LEN):0]   waddr,
    input  wire logic [DATA_W-1:0]           wdata,
    input  wire logic                        re,
    input  wire logic [$clog2(LINE_LEN):0]   raddr,
    output logic      [DATA_W-1:0]           q
);

    localparam int c_iw = $clog2(LINE_LEN);
    localparam int c_mw = $clog2(2 * LINE_LEN);

    logic [DATA_W-1:0] r_mem [2*LINE_LEN];
    logic [DATA_W-1:0] r_q;
    logic [c_mw-1:0]   w_wr_idx;
    logic [c_mw-1:0]   w_rd_idx;

    // Address MSB picks the buffer; the pong half starts right after the ping half.
    function automatic logic [c_mw-1:0] f_index(input logic [c_iw:0] a);
        return a[c_iw] ? c_mw'(LINE_LEN) + c_mw'(a[c_iw-1:0]) : c_mw'(a[c_iw-1:0]);
    endfunction

    assign w_wr_idx = f_index(waddr);
    assign w_rd_idx = f_index(raddr);

    always_ff @(posedge clk_pix) begin
        if (we) begin
            r_mem[w_wr_idx] <= wdata;
        end
        if (re) begin
            r_q <= r_mem[w_rd_idx];
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/vga_line_fetch.sv
// ============================================================================
// Module : vga_line_fetch
// Brief  : Prefetches the next visible line into a ping-pong buffer and drives
//          RGB aligned with 2-cycle delayed sync/de.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_line_fetch
    import vga_line_fetch_pkg::*;
#(
    parameter int H_VISIBLE = c_h_visible,
    parameter int V_VISIBLE = c_v_visible,
    parameter int V_TOTAL   = c_v_total,
    parameter int PIX_W     = c_pix_w,
    parameter int MEM_AW    = c_mem_aw,
    parameter int FB_BASE   = c_fb_base
) (
    input  wire logic             clk_pix,
    input  wire logic             resetn,
    input  wire logic [9:0]       hcount,
    input  wire logic [9:0]       vcount,
    input  wire logic             hsync_in,
    input  wire logic             vsync_in,
    input  wire logic             de_in,
    vga_line_fetch_if.master      mem,
    output logic      [PIX_W-1:0] rgb,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  de_out,
    output logic                  underrun
);

    localparam int              c_idx_w         = $clog2(H_VISIBLE);
    localparam int              c_cnt_w         = $clog2(H_VISIBLE + 1);
    localparam logic [9:0]      c_last_line     = 10'(V_TOTAL - 1);
    localparam logic [9:0]      c_last_prefetch = 10'(V_VISIBLE - 2);
    localparam logic [c_cnt_w-1:0] c_last_cnt   = c_cnt_w'(H_VISIBLE - 1);

    fetch_state_t       r_state;
    logic               r_wr_buf;
    logic [c_cnt_w-1:0] r_req_cnt;
    logic [c_cnt_w-1:0] r_rsp_cnt;
    logic [MEM_AW-1:0]  r_line_base;
    logic               r_req_valid;
    logic               r_underrun;

    logic               w_trig;
    logic [9:0]         w_target;
    logic [MEM_AW-1:0]  w_line_base;
    logic               w_accept;
    logic               w_rsp;
    logic               w_last_acc;
    logic               w_last_rsp;
    logic [PIX_W-1:0]   w_ram_q;

    // Line V_TOTAL-1 prefetches line 0; visible lines prefetch their successor.
    assign w_trig      = (hcount == 10'd0) &&
                         ((vcount == c_last_line) || (vcount <= c_last_prefetch));
    assign w_target    = (vcount == c_last_line) ? 10'd0 : vcount + 10'd1;
    assign w_line_base = MEM_AW'(FB_BASE) + MEM_AW'(w_target) * MEM_AW'(H_VISIBLE);

    assign w_accept   = r_req_valid && mem.mem_req_ready;
    assign w_rsp      = (r_state != IDLE) && mem.mem_rsp_valid;
    assign w_last_acc = w_accept && (r_req_cnt == c_last_cnt);
    assign w_last_rsp = w_rsp && (r_rsp_cnt == c_last_cnt);

    assign mem.mem_req_valid = r_req_valid;
    assign mem.mem_req_addr  = r_line_base + MEM_AW'(r_req_cnt);
    assign underrun          = r_underrun;

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_wr_buf    <= 1'b0;
            r_req_cnt   <= '0;
            r_rsp_cnt   <= '0;
            r_line_base <= '0;
            r_req_valid <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= w_trig && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        r_state     <= REQ;
                        r_wr_buf    <= w_target[0];
                        r_line_base <= w_line_base;
                        r_req_cnt   <= '0;
                        r_rsp_cnt   <= '0;
                        r_req_valid <= 1'b1;
                    end
                end
                REQ: begin
                    if (w_accept) begin
                        r_req_cnt <= r_req_cnt + 1'b1;
                    end
                    if (w_rsp) begin
                        r_rsp_cnt <= r_rsp_cnt + 1'b1;
                    end
                    // With zero-latency memory the last response can coincide with the last accept.
                    if (w_last_acc) begin
                        r_req_valid <= 1'b0;
                        r_state     <= w_last_rsp ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_rsp) begin
                        r_rsp_cnt <= r_rsp_cnt + 1'b1;
                    end
                    if (w_last_rsp) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    vga_line_ram #(
        .DATA_W   (PIX_W),
        .LINE_LEN (H_VISIBLE)
    ) u_line_ram (
        .clk_pix (clk_pix),
        .we      (w_rsp),
        .waddr   ({r_wr_buf, r_rsp_cnt[c_idx_w-1:0]}),
        .wdata   (mem.mem_rsp_data),
        .re      (de_in),
        .raddr   ({vcount[0], hcount[c_idx_w-1:0]}),
        .q       (w_ram_q)
    );

    logic             r_hs1, r_vs1, r_de1;
    logic             r_hs2, r_vs2, r_de2;
    logic [PIX_W-1:0] r_rgb;

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_hs1 <= 1'b1;
            r_vs1 <= 1'b1;
            r_de1 <= 1'b0;
            r_hs2 <= 1'b1;
            r_vs2 <= 1'b1;
            r_de2 <= 1'b0;
            r_rgb <= '0;
        end else begin
            r_hs1 <= hsync_in;
            r_vs1 <= vsync_in;
            r_de1 <= de_in;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            r_de2 <= r_de1;
            r_rgb <= r_de1 ? w_ram_q : '0;
        end
    end

    assign rgb       = r_rgb;
    assign hsync_out = r_hs2;
    assign vsync_out = r_vs2;
    assign de_out    = r_de2;

endmodule

`default_nettype wire
